// File: rtl/mouse_pkg.sv
// Shared types and screen constants for the mouse input conditioning path.
package mouse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    HOLD,
    COOLDOWN
  } shot_state_t;

  localparam int unsigned COORD_W   = 12;
  localparam int unsigned X_MAX_DEF = 1023;
  localparam int unsigned Y_MAX_DEF = 767;

  // Unsigned saturation of one coordinate axis to its screen limit.
  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Generic single-bit two-flop synchroniser with asynchronous active-high reset.
module sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mouse_input_cond.sv
// Mouse input conditioning: stability-filtered, clamped position plus
// rate-limited single-shot button pulses with latched aim coordinates.
module mouse_input_cond
  import mouse_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES   = 4,
  parameter int unsigned X_MAX           = X_MAX_DEF,
  parameter int unsigned Y_MAX           = Y_MAX_DEF,
  parameter int unsigned COOLDOWN_CYCLES = 6_500_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] xpos_in,
  input  logic [COORD_W-1:0] ypos_in,
  input  logic               left_in,
  output logic [COORD_W-1:0] xpos_out,
  output logic [COORD_W-1:0] ypos_out,
  output logic               pos_upd,
  output logic               shot,
  output logic [COORD_W-1:0] shot_x,
  output logic [COORD_W-1:0] shot_y
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES);
  localparam int unsigned CW = $clog2(COOLDOWN_CYCLES);
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);

  logic [COORD_W-1:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [COORD_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [SW-1:0]      stab_cnt_q, stab_cnt_d;
  logic               pos_upd_q, pos_upd_d;
  shot_state_t        state_q, state_d;
  logic [CW-1:0]      cool_cnt_q, cool_cnt_d;
  logic               shot_q, shot_d;
  logic [COORD_W-1:0] shot_x_q, shot_x_d, shot_y_q, shot_y_d;

  logic               match;
  logic               accept;
  logic [COORD_W-1:0] clamp_x, clamp_y;
  logic               left_s;

  sync_bit u_left_sync (
    .clk (clk),
    .rst (rst),
    .d   (left_in),
    .q   (left_s)
  );

  // Position stabiliser: accept a pair only after STABLE_CYCLES identical samples.
  always_comb begin
    prev_x_d   = xpos_in;
    prev_y_d   = ypos_in;
    match      = ({xpos_in, ypos_in} == {prev_x_q, prev_y_q});
    accept     = match && (stab_cnt_q == SW'(STABLE_CYCLES - 2));
    clamp_x    = clamp_coord(xpos_in, X_LIM);
    clamp_y    = clamp_coord(ypos_in, Y_LIM);
    stab_cnt_d = '0;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    pos_upd_d  = 1'b0;
    if (match) begin
      stab_cnt_d = (stab_cnt_q == SW'(STABLE_CYCLES - 1)) ? stab_cnt_q
                                                          : stab_cnt_q + SW'(1);
    end
    if (accept && ({clamp_x, clamp_y} != {xpos_q, ypos_q})) begin
      xpos_d    = clamp_x;
      ypos_d    = clamp_y;
      pos_upd_d = 1'b1;
    end
  end

  // Shot FSM: one shot per press, re-armed only after a full release cooldown.
  always_comb begin
    state_d    = state_q;
    cool_cnt_d = cool_cnt_q;
    shot_d     = 1'b0;
    shot_x_d   = shot_x_q;
    shot_y_d   = shot_y_q;
    case (state_q)
      IDLE: begin
        if (left_s) begin
          state_d  = FIRE;
          shot_d   = 1'b1;
          shot_x_d = xpos_q;
          shot_y_d = ypos_q;
        end
      end
      FIRE: state_d = HOLD;
      HOLD: begin
        if (!left_s) begin
          state_d    = COOLDOWN;
          cool_cnt_d = '0;
        end
      end
      COOLDOWN: begin
        if (left_s) begin
          state_d = HOLD;
        end else if (cool_cnt_q == CW'(COOLDOWN_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          cool_cnt_d = cool_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      stab_cnt_q <= '0;
      xpos_q     <= '0;
      ypos_q     <= '0;
      pos_upd_q  <= 1'b0;
      state_q    <= IDLE;
      cool_cnt_q <= '0;
      shot_q     <= 1'b0;
      shot_x_q   <= '0;
      shot_y_q   <= '0;
    end else begin
      prev_x_q   <= prev_x_d;
      prev_y_q   <= prev_y_d;
      stab_cnt_q <= stab_cnt_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      pos_upd_q  <= pos_upd_d;
      state_q    <= state_d;
      cool_cnt_q <= cool_cnt_d;
      shot_q     <= shot_d;
      shot_x_q   <= shot_x_d;
      shot_y_q   <= shot_y_d;
    end
  end

  assign xpos_out = xpos_q;
  assign ypos_out = ypos_q;
  assign pos_upd  = pos_upd_q;
  assign shot     = shot_q;
  assign shot_x   = shot_x_q;
  assign shot_y   = shot_y_q;

endmodule

// File: tb/tb_mouse_input_cond.sv
// Bench for mouse_input_cond: directed scenarios, per-cycle model comparison, literal pins.
module tb_mouse_input_cond;

  localparam int S  = 4;
  localparam int C  = 10;
  localparam int XM = 1023;
  localparam int YM = 767;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos_in = '0;
  logic [11:0] ypos_in = '0;
  logic        left_in = 1'b0;
  logic [11:0] xpos_out, ypos_out, shot_x, shot_y;
  logic        pos_upd, shot;

  int checks = 0;
  int errors = 0;

  mouse_input_cond #(
    .STABLE_CYCLES   (S),
    .X_MAX           (XM),
    .Y_MAX           (YM),
    .COOLDOWN_CYCLES (C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .xpos_in  (xpos_in),
    .ypos_in  (ypos_in),
    .left_in  (left_in),
    .xpos_out (xpos_out),
    .ypos_out (ypos_out),
    .pos_upd  (pos_upd),
    .shot     (shot),
    .shot_x   (shot_x),
    .shot_y   (shot_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: run-length of identical samples for position,
  // armed flag plus count of consecutive released samples for the button.
  int m_x = 0, m_y = 0, m_upd = 0, m_shot = 0, m_sx = 0, m_sy = 0;
  int last_x = 0, last_y = 0, run = 1, lowrun = 0;
  int cx, cy;
  bit ms1 = 0, ms2 = 0, m_s, armed = 1, skip = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_x = 0; m_y = 0; m_upd = 0; m_shot = 0; m_sx = 0; m_sy = 0;
      last_x = 0; last_y = 0; run = 1; lowrun = 0;
      ms1 = 0; ms2 = 0; armed = 1; skip = 0;
    end else begin
      m_s = ms2; ms2 = ms1; ms1 = left_in;
      m_shot = 0;
      if (armed && m_s) begin
        m_shot = 1; m_sx = m_x; m_sy = m_y;
        armed = 0; skip = 1; lowrun = 0;
      end else if (!armed) begin
        if (skip) skip = 0;
        else if (m_s) lowrun = 0;
        else begin
          lowrun++;
          if (lowrun == C + 1) armed = 1;
        end
      end
      if (int'(xpos_in) == last_x && int'(ypos_in) == last_y) begin
        if (run <= S) run++;
      end else begin
        last_x = int'(xpos_in); last_y = int'(ypos_in); run = 1;
      end
      cx = (last_x > XM) ? XM : last_x;
      cy = (last_y > YM) ? YM : last_y;
      m_upd = 0;
      if (run == S && (cx != m_x || cy != m_y)) begin
        m_x = cx; m_y = cy; m_upd = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_xpos_out", 32'(xpos_out), 32'(m_x));
    check("cyc_ypos_out", 32'(ypos_out), 32'(m_y));
    check("cyc_pos_upd",  32'(pos_upd),  32'(m_upd));
    check("cyc_shot",     32'(shot),     32'(m_shot));
    check("cyc_shot_x",   32'(shot_x),   32'(m_sx));
    check("cyc_shot_y",   32'(shot_y),   32'(m_sy));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pos(input int x, input int y);
    xpos_in = 12'(x);
    ypos_in = 12'(y);
  endtask

  int cnt, first;

  initial begin
    step(3);
    rst = 1'b0;
    check("rst_xpos", 32'(xpos_out), 0);
    check("rst_shot_x", 32'(shot_x), 0);

    // 1: stable (100,200) accepted on the third edge after the first sample
    set_pos(100, 200);
    step(3);
    check("t1_before_accept", 32'(xpos_out), 0);
    step(1);
    check("t1_xpos", 32'(xpos_out), 100);
    check("t1_ypos", 32'(ypos_out), 200);
    check("t1_pos_upd", 32'(pos_upd), 1);
    step(1);
    check("t1_pos_upd_clear", 32'(pos_upd), 0);

    // 2: one-cycle glitch never reaches the outputs
    cnt = 0;
    set_pos(4095, 0);
    step(1);
    if (pos_upd) cnt++;
    set_pos(100, 200);
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (pos_upd) cnt++;
    end
    check("t2_glitch_upd", 32'(cnt), 0);
    check("t2_xpos", 32'(xpos_out), 100);

    // 3: clamping, then a different raw value with the same clamped result
    set_pos(2000, 900);
    step(6);
    check("t3_xclamp", 32'(xpos_out), 1023);
    check("t3_yclamp", 32'(ypos_out), 767);
    cnt = 0;
    set_pos(1500, 800);
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (pos_upd) cnt++;
    end
    check("t3_same_clamp_upd", 32'(cnt), 0);

    // 4: one shot per press, three edges after the press
    set_pos(300, 400);
    step(6);
    left_in = 1'b1;
    cnt = 0;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (shot) begin
        cnt++;
        if (first == 0) begin
          first = k;
          check("t4_shot_x", 32'(shot_x), 300);
          check("t4_shot_y", 32'(shot_y), 400);
        end
      end
    end
    check("t4_shot_count", 32'(cnt), 1);
    check("t4_shot_latency", 32'(first), 3);

    // 5: early re-press restarts cooldown; a press after full cooldown fires
    cnt = 0;
    left_in = 1'b0;
    for (int i = 0; i < 5; i++) begin step(1); if (shot) cnt++; end
    left_in = 1'b1;
    for (int i = 0; i < 6; i++) begin step(1); if (shot) cnt++; end
    left_in = 1'b0;
    for (int i = 0; i < 12; i++) begin step(1); if (shot) cnt++; end
    check("t5_early_repress", 32'(cnt), 0);
    left_in = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin step(1); if (shot) cnt++; end
    check("t5_after_cooldown", 32'(cnt), 1);

    // 6: asynchronous reset in the middle of cooldown
    left_in = 1'b0;
    step(4);
    #3;
    rst = 1'b1;
    #1;
    check("t6_xpos", 32'(xpos_out), 0);
    check("t6_ypos", 32'(ypos_out), 0);
    check("t6_shot", 32'(shot), 0);
    check("t6_shot_x", 32'(shot_x), 0);
    check("t6_shot_y", 32'(shot_y), 0);
    step(2);
    rst = 1'b0;
    step(8);
    check("t6_reaccept", 32'(xpos_out), 300);

    // 7: position accepted in the FIRE cycle is not captured by the shot
    set_pos(500, 600);
    step(1);
    left_in = 1'b1;
    step(3);
    check("t7_shot", 32'(shot), 1);
    check("t7_pos_upd", 32'(pos_upd), 1);
    check("t7_xpos_new", 32'(xpos_out), 500);
    check("t7_shot_x_old", 32'(shot_x), 300);
    check("t7_shot_y_old", 32'(shot_y), 400);
    left_in = 1'b0;
    step(15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
